// File: rtl/rotor_stepper.sv
// Three-rotor position register with odometer stepping, feeding the Enigma letter shifter.
// Each accepted character is registered together with its mode and the combined rotor offset.
module rotor_stepper #(
    parameter int NOTCH0 = 25,
    parameter int NOTCH1 = 25
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_pos0,
    input  logic [7:0] load_pos1,
    input  logic [7:0] load_pos2,
    output logic       load_err,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] char_in,
    input  logic       encrypt_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] char_out,
    output logic       encrypt_out,
    output logic [7:0] rotor_value,
    output logic [7:0] pos0,
    output logic [7:0] pos1,
    output logic [7:0] pos2
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // valid never waits on ready; the output entry is held while out_valid & !out_ready.
    localparam logic [7:0] N0 = 8'(NOTCH0);
    localparam logic [7:0] N1 = 8'(NOTCH1);

    logic [7:0] pos0_q, pos0_d, pos1_q, pos1_d, pos2_q, pos2_d;
    logic [7:0] char_q, char_d, rv_q, rv_d;
    logic       enc_q, enc_d, ov_q, ov_d, lerr_q, lerr_d;
    logic       accept, load_ok, c1, c2;
    logic [8:0] sum_raw, sum_1, sum_2;

    function automatic logic [7:0] inc26(input logic [7:0] p);
        return (p == 8'd25) ? 8'd0 : p + 8'd1;
    endfunction

    assign in_ready = !load && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign load_ok  = (load_pos0 <= 8'd25) && (load_pos1 <= 8'd25) && (load_pos2 <= 8'd25);
    assign c1       = (pos0_q == N0);
    assign c2       = c1 && (pos1_q == N1);

    always_comb begin
        sum_raw = {1'b0, pos0_q} + {1'b0, pos1_q} + {1'b0, pos2_q};
        sum_1   = (sum_raw >= 9'd26) ? sum_raw - 9'd26 : sum_raw;
        sum_2   = (sum_1 >= 9'd26) ? sum_1 - 9'd26 : sum_1;

        pos0_d  = pos0_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        char_d  = char_q;
        enc_d   = enc_q;
        rv_d    = rv_q;
        ov_d    = ov_q;
        lerr_d  = load && !load_ok;

        if (load) begin
            if (load_ok) begin
                pos0_d = load_pos0;
                pos1_d = load_pos1;
                pos2_d = load_pos2;
            end
        end else if (accept) begin
            pos0_d = inc26(pos0_q);
            pos1_d = c1 ? inc26(pos1_q) : pos1_q;
            pos2_d = c2 ? inc26(pos2_q) : pos2_q;
        end

        if (accept) begin
            char_d = char_in;
            enc_d  = encrypt_in;
            rv_d   = sum_2[7:0];
            ov_d   = 1'b1;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos0_q <= 8'd0;
            pos1_q <= 8'd0;
            pos2_q <= 8'd0;
            char_q <= 8'd0;
            enc_q  <= 1'b0;
            rv_q   <= 8'd0;
            ov_q   <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            pos0_q <= pos0_d;
            pos1_q <= pos1_d;
            pos2_q <= pos2_d;
            char_q <= char_d;
            enc_q  <= enc_d;
            rv_q   <= rv_d;
            ov_q   <= ov_d;
            lerr_q <= lerr_d;
        end
    end

    assign load_err    = lerr_q;
    assign out_valid   = ov_q;
    assign char_out    = char_q;
    assign encrypt_out = enc_q;
    assign rotor_value = rv_q;
    assign pos0        = pos0_q;
    assign pos1        = pos1_q;
    assign pos2        = pos2_q;
endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: queued expected outputs checked by a delivery monitor,
// plus direct checks of positions, load_err, in_ready and reset behaviour.
module tb_rotor_stepper;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_pos0 = 8'd0, load_pos1 = 8'd0, load_pos2 = 8'd0;
    logic       load_err;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] char_in = 8'd0;
    logic       encrypt_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] char_out;
    logic       encrypt_out;
    logic [7:0] rotor_value;
    logic [7:0] pos0, pos1, pos2;

    int tests = 0;
    int fails = 0;
    logic [16:0] exp_q[$];

    rotor_stepper dut (
        .clk(clk), .resetn(resetn), .load(load),
        .load_pos0(load_pos0), .load_pos1(load_pos1), .load_pos2(load_pos2),
        .load_err(load_err), .in_valid(in_valid), .in_ready(in_ready),
        .char_in(char_in), .encrypt_in(encrypt_in), .out_valid(out_valid),
        .out_ready(out_ready), .char_out(char_out), .encrypt_out(encrypt_out),
        .rotor_value(rotor_value), .pos0(pos0), .pos1(pos1), .pos2(pos2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every delivered output against the queue head
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 32'(char_out), 32'hFFFF_FFFF);
            end else begin
                check("delivery", 32'({encrypt_out, char_out, rotor_value}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] c, input logic e, input logic [7:0] exp_rv);
        int waits;
        in_valid   = 1'b1;
        char_in    = c;
        encrypt_in = e;
        exp_q.push_back({e, c, exp_rv});
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) check("send_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        load      = 1'b1;
        load_pos0 = a;
        load_pos1 = b;
        load_pos2 = c;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        check(name, 32'({pos0, pos1, pos2}), 32'({a, b, c}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_regs", 32'({char_out, encrypt_out, rotor_value, load_err}), 32'd0);
        check_pos("rst_pos", 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // first char, positions 0,0,0
        send(8'h41, 1'b1, 8'd0);
        check("first_out_valid", 32'(out_valid), 32'd1);
        check_pos("first_pos", 8'd1, 8'd0, 8'd0);
        idle(2);

        // full odometer wrap: 25+25+25 = 75 -> 23
        do_load(8'd25, 8'd25, 8'd25);
        check_pos("load_25s", 8'd25, 8'd25, 8'd25);
        send(8'h42, 1'b0, 8'd23);
        check_pos("wrap_pos", 8'd0, 8'd0, 8'd0);
        idle(2);

        // back-to-back: 24,3,7 -> 25,3,7 -> 0,4,7 -> 1,4,7; offsets 8, 9, 11
        do_load(8'd24, 8'd3, 8'd7);
        t0 = $time;
        send(8'h61, 1'b1, 8'd8);
        send(8'h62, 1'b0, 8'd9);
        send(8'h63, 1'b1, 8'd11);
        check("b2b_cycles", 32'($time - t0), 32'd30);
        check_pos("b2b_pos", 8'd1, 8'd4, 8'd7);
        idle(2);

        // backpressure: 0x50 pending (offset 12), 0x51 offered while stalled
        out_ready = 1'b0;
        send(8'h50, 1'b0, 8'd12);
        in_valid   = 1'b1;
        char_in    = 8'h51;
        encrypt_in = 1'b1;
        exp_q.push_back({1'b1, 8'h51, 8'd13});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'({out_valid, char_out, rotor_value}), 32'({1'b1, 8'h50, 8'd12}));
            check("bp_pos0", 32'(pos0), 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_pos("bp_after", 8'd3, 8'd4, 8'd7);
        idle(2);

        // rejected load
        do_load(8'd3, 8'd30, 8'd0);
        check("lerr_pulse", 32'(load_err), 32'd1);
        check_pos("lerr_pos", 8'd3, 8'd4, 8'd7);
        idle(1);
        check("lerr_clear", 32'(load_err), 32'd0);

        // load together with in_valid: char not accepted, positions load unstepped
        in_valid   = 1'b1;
        char_in    = 8'h60;
        load       = 1'b1;
        load_pos0  = 8'd5;
        load_pos1  = 8'd6;
        load_pos2  = 8'd7;
        @(negedge clk);
        check("load_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        load     = 1'b0;
        in_valid = 1'b0;
        check_pos("load_valid_pos", 8'd5, 8'd6, 8'd7);
        check("load_no_accept", 32'(out_valid), 32'd0);
        check("load_ok_no_err", 32'(load_err), 32'd0);

        // reset mid-transfer with a pending entry
        out_ready = 1'b0;
        send(8'h70, 1'b1, 8'd18);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check_pos("async_rst_pos", 8'd0, 8'd0, 8'd0);
        void'(exp_q.pop_back());
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
